// File: rtl/arp_req_tx.sv
// ARP request generator: on a table miss it broadcasts oper=1 frames on the MAC tx path.
// It retries on timeout until a matching rx update arrives or RETRIES frames have gone unanswered.
module arp_req_tx #(
  parameter int unsigned TIMEOUT_TICKS = 125000,
  parameter int unsigned RETRIES       = 3,
  parameter int unsigned LEN           = 46
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] dev_mac,
  input  logic [31:0] dev_ipv4,
  input  logic        req,
  input  logic [31:0] tgt_ipv4,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        rsp_val,
  input  logic [31:0] rsp_ipv4,
  output logic        tx_req,
  input  logic        tx_gnt,
  output logic        tx_v,
  output logic [7:0]  tx_d,
  output logic [47:0] tx_dst_mac,
  output logic [15:0] tx_ethertype
);

  localparam int unsigned TW = $clog2(TIMEOUT_TICKS);
  localparam int unsigned CW = $clog2(RETRIES + 1);
  localparam int unsigned BW = 6;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_SEND     = 2'd2,
    S_WAIT_RSP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     tgt_q, tgt_d;
  logic [47:0]     mac_q, mac_d;
  logic [31:0]     ip_q, ip_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   try_q, try_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            hit_q, hit_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            tx_req_q, tx_req_d;
  logic            tx_v_q, tx_v_d;
  logic [7:0]      tx_d_q, tx_d_d;
  logic            match_c;
  logic            hit_c;

  // ARP header byte at a given payload index; everything past the header is zero pad.
  function automatic logic [7:0] byte_at(input logic [BW-1:0] idx, input logic [47:0] mac,
                                         input logic [31:0] ip, input logic [31:0] tgt);
    logic [7:0] b;
    case (idx)
      6'd1:    b = 8'h01;
      6'd2:    b = 8'h08;
      6'd4:    b = 8'd6;
      6'd5:    b = 8'd4;
      6'd7:    b = 8'h01;
      6'd8:    b = mac[47:40];
      6'd9:    b = mac[39:32];
      6'd10:   b = mac[31:24];
      6'd11:   b = mac[23:16];
      6'd12:   b = mac[15:8];
      6'd13:   b = mac[7:0];
      6'd14:   b = ip[31:24];
      6'd15:   b = ip[23:16];
      6'd16:   b = ip[15:8];
      6'd17:   b = ip[7:0];
      6'd24:   b = tgt[31:24];
      6'd25:   b = tgt[23:16];
      6'd26:   b = tgt[15:8];
      6'd27:   b = tgt[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign match_c = rsp_val && (rsp_ipv4 == tgt_q);
  assign hit_c   = hit_q || match_c;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    mac_d    = mac_q;
    ip_d     = ip_q;
    cnt_d    = cnt_q;
    try_d    = try_q;
    timer_d  = timer_q;
    hit_d    = hit_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tx_req_d = tx_req_q;
    tx_v_d   = tx_v_q;
    tx_d_d   = tx_d_q;

    case (state_q)
      S_IDLE: begin
        if (req && (tgt_ipv4 != 32'd0)) begin
          tgt_d    = tgt_ipv4;
          mac_d    = dev_mac;
          ip_d     = dev_ipv4;
          try_d    = '0;
          hit_d    = 1'b0;
          tx_req_d = 1'b1;
          state_d  = S_WAIT_GNT;
        end
      end
      S_WAIT_GNT: begin
        if (match_c) begin
          done_d   = 1'b1;
          tx_req_d = 1'b0;
          state_d  = S_IDLE;
        end else if (tx_gnt) begin
          cnt_d   = '0;
          tx_v_d  = 1'b1;
          tx_d_d  = byte_at(BW'(0), mac_q, ip_q, tgt_q);
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // A reply seen mid-frame is remembered; the frame always completes.
        if (cnt_q == BW'(LEN - 1)) begin
          tx_v_d   = 1'b0;
          tx_req_d = 1'b0;
          tx_d_d   = 8'h00;
          try_d    = try_q + CW'(1);
          timer_d  = '0;
          hit_d    = 1'b0;
          if (hit_c) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_RSP;
          end
        end else begin
          cnt_d  = cnt_q + BW'(1);
          tx_d_d = byte_at(cnt_q + BW'(1), mac_q, ip_q, tgt_q);
          hit_d  = hit_c;
        end
      end
      S_WAIT_RSP: begin
        if (match_c) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q >= TW'(TIMEOUT_TICKS - 1)) begin
          if (try_q >= CW'(RETRIES)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            tx_req_d = 1'b1;
            state_d  = S_WAIT_GNT;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      mac_q    <= '0;
      ip_q     <= '0;
      cnt_q    <= '0;
      try_q    <= '0;
      timer_q  <= '0;
      hit_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tx_req_q <= 1'b0;
      tx_v_q   <= 1'b0;
      tx_d_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      mac_q    <= mac_d;
      ip_q     <= ip_d;
      cnt_q    <= cnt_d;
      try_q    <= try_d;
      timer_q  <= timer_d;
      hit_q    <= hit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tx_req_q <= tx_req_d;
      tx_v_q   <= tx_v_d;
      tx_d_q   <= tx_d_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign tx_req       = tx_req_q;
  assign tx_v         = tx_v_q;
  assign tx_d         = tx_d_q;
  assign tx_dst_mac   = 48'hFFFF_FFFF_FFFF;
  assign tx_ethertype = 16'h0806;

endmodule
